// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INCR = 32'h0000_0004;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  // Word-align an address (low two bits forced to zero).
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register that catches a response
// arriving while decode is stalled on the previous instruction.
module fetch_skid_buf import riscv_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        load,
  input  logic        pop,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  // Flush beats load, load beats pop; the data fields only change on load.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= 32'h0000_0000;
      pc    <= 32'h0000_0000;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (pop) begin
      valid <= 1'b0;
    end else begin
      valid <= valid;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, runs the imem request/response
// handshake, buffers one response under decode stall and squashes
// wrong-path fetches on an EX-stage redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] PC_n
);

  import riscv_pkg::*;

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic [31:0]  pending_pc_r;

  logic         skid_valid_s;
  logic [31:0]  skid_instr_s;
  logic [31:0]  skid_pc_s;

  logic         accept_s;
  logic         deliver_s;
  logic         consume_s;
  logic         skid_load_s;
  logic         skid_pop_s;
  logic         outstanding_s;
  logic [31:0]  redirect_target_s;

  assign imem_addr         = pc_r;
  assign accept_s          = imem_req && imem_ready;
  // A redirect in the response cycle turns the data into wrong-path data.
  assign deliver_s         = imem_rvalid && (state_r == S_WAIT) && !redirect_valid;
  assign consume_s         = instr_valid && !stall;
  assign skid_load_s       = deliver_s && instr_valid && stall;
  assign skid_pop_s        = consume_s && skid_valid_s;
  assign redirect_target_s = align_pc(redirect_pc);

  // Request only from S_REQ, and only when the skid has room for the answer.
  always_comb begin
    imem_req = 1'b0;
    if (reset) begin
      imem_req = 1'b0;
    end else if (state_r == S_REQ) begin
      imem_req = !skid_valid_s;
    end else begin
      imem_req = 1'b0;
    end
  end

  // Is a memory response still owed once this cycle completes?
  always_comb begin
    outstanding_s = 1'b0;
    case (state_r)
      S_REQ:   outstanding_s = accept_s;
      S_WAIT:  outstanding_s = !imem_rvalid;
      S_DROP:  outstanding_s = !imem_rvalid;
      default: outstanding_s = 1'b0;
    endcase
  end

  // Fetch FSM and PC; a redirect never lets an accepted request advance pc.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_REQ;
      pc_r         <= RESET_PC;
      pending_pc_r <= 32'h0000_0000;
    end else if (redirect_valid) begin
      pc_r    <= redirect_target_s;
      state_r <= outstanding_s ? S_DROP : S_REQ;
    end else begin
      case (state_r)
        S_REQ: begin
          if (accept_s) begin
            pending_pc_r <= pc_r;
            pc_r         <= pc_r + PC_INCR;
            state_r      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_r <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state_r <= S_REQ;
          end
        end
        default: state_r <= S_REQ;
      endcase
    end
  end

  // Decode-facing output register; held untouched while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      PC_n        <= 32'h0000_0000;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
    end else if (consume_s) begin
      if (skid_valid_s) begin
        instr_valid <= 1'b1;
        instr       <= skid_instr_s;
        PC_n        <= skid_pc_s;
      end else if (deliver_s) begin
        instr_valid <= 1'b1;
        instr       <= imem_rdata;
        PC_n        <= pending_pc_r;
      end else begin
        instr_valid <= 1'b0;
        instr       <= NOP_INSTR;
      end
    end else if (!instr_valid && deliver_s) begin
      instr_valid <= 1'b1;
      instr       <= imem_rdata;
      PC_n        <= pending_pc_r;
    end else begin
      instr_valid <= instr_valid;
    end
  end

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .load       (skid_load_s),
    .pop        (skid_pop_s),
    .load_instr (imem_rdata),
    .load_pc    (pending_pc_r),
    .valid      (skid_valid_s),
    .instr      (skid_instr_s),
    .pc         (skid_pc_s)
  );

endmodule
